// File: rtl/regfile_sequencer_pkg.sv
// Shared types and defaults for the register-file sequencer.
// Opcode and state encodings are used by the top and the ALU.
package regfile_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IMM_W_DEF  = 8;

  typedef enum logic [2:0] {
    OP_MOV_IMM = 3'd0,
    OP_MOV     = 3'd1,
    OP_ADD     = 3'd2,
    OP_CMP     = 3'd3,
    OP_AND     = 3'd4,
    OP_MVN     = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic is_illegal(input logic [2:0] op);
    return op > 3'd5;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Command handshake, register-file port and status bundle of the sequencer.
// slave = the sequencer; master = decoder plus register file side.
interface regfile_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_rd;
  logic [2:0]        cmd_rn;
  logic [2:0]        cmd_rm;
  logic [IMM_W-1:0]  cmd_imm;
  logic [2:0]        rf_readnum;
  logic [DATA_W-1:0] rf_data_out;
  logic [2:0]        rf_writenum;
  logic              rf_write;
  logic [DATA_W-1:0] rf_data_in;
  logic              done;
  logic              err;
  logic              busy;
  logic              flag_z;
  logic              flag_n;
  logic              flag_v;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, rf_data_out,
    output cmd_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
    output done, err, busy, flag_z, flag_n, flag_v
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, rf_data_out,
    input  cmd_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
    input  done, err, busy, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU for the sequencer EXEC step; zero latency.
// z/n/v always describe A - B; result is meaningful for MOV/ADD/AND/MVN.
module rfseq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_z,
  output logic              o_n,
  output logic              o_v
);

  logic [DATA_W-1:0] w_diff;

  assign w_diff = i_a - i_b;

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_MOV:  o_result = i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_MVN:  o_result = ~i_b;
      default: o_result = w_diff;
    endcase
  end

  // Overflow when operand signs differ and the result sign differs from A.
  assign o_z = (w_diff == '0);
  assign o_n = w_diff[DATA_W-1];
  assign o_v = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) & (w_diff[DATA_W-1] ^ i_a[DATA_W-1]);

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle read/execute/write sequencer driving an 8x16 register file.
// Latency 1..5 cycles by opcode; cmd_ready only in IDLE, so one command in flight.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  regfile_sequencer_if.slave bus
);

  state_e            r_state;
  state_e            w_next;
  logic [2:0]        r_op;
  logic [2:0]        r_rd;
  logic [2:0]        r_rn;
  logic [2:0]        r_rm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic              r_z;
  logic              r_n;
  logic              r_v;
  logic              w_accept;
  logic [DATA_W-1:0] w_result;
  logic              w_z;
  logic              w_n;
  logic              w_v;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  rfseq_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_result),
    .o_z      (w_z),
    .o_n      (w_n),
    .o_v      (w_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_MOV_IMM:            w_next = S_WRITE;
            OP_MOV, OP_MVN:        w_next = S_READ_B;
            OP_ADD, OP_CMP, OP_AND: w_next = S_READ_A;
            default:               w_next = S_DONE;
          endcase
        end
      end
      S_READ_A: w_next = S_READ_B;
      S_READ_B: w_next = S_EXEC;
      S_EXEC:   w_next = (r_op == OP_CMP) ? S_DONE : S_WRITE;
      S_WRITE:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= '0;
      r_rd <= '0;
      r_rn <= '0;
      r_rm <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_z  <= 1'b0;
      r_n  <= 1'b0;
      r_v  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= bus.cmd_op;
        r_rd <= bus.cmd_rd;
        r_rn <= bus.cmd_rn;
        r_rm <= bus.cmd_rm;
        if (bus.cmd_op == OP_MOV_IMM)
          r_c <= {{(DATA_W-IMM_W){bus.cmd_imm[IMM_W-1]}}, bus.cmd_imm};
      end
      if (r_state == S_READ_A) r_a <= bus.rf_data_out;
      if (r_state == S_READ_B) r_b <= bus.rf_data_out;
      if (r_state == S_EXEC) begin
        if (r_op == OP_CMP) begin
          r_z <= w_z;
          r_n <= w_n;
          r_v <= w_v;
        end else begin
          r_c <= w_result;
        end
      end
    end
  end

  // All register-file and status outputs decode from state alone.
  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.busy        = 1'b1;
    bus.rf_readnum  = 3'd0;
    bus.rf_writenum = 3'd0;
    bus.rf_write    = 1'b0;
    bus.rf_data_in  = '0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      S_READ_A: bus.rf_readnum = r_rn;
      S_READ_B: bus.rf_readnum = r_rm;
      S_WRITE: begin
        bus.rf_write    = 1'b1;
        bus.rf_writenum = r_rd;
        bus.rf_data_in  = r_c;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = is_illegal(r_op);
      end
      default: ;
    endcase
  end

  assign bus.flag_z = r_z;
  assign bus.flag_n = r_n;
  assign bus.flag_v = r_v;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboarded bench: register file model, directed cases, then random commands.
`timescale 1ns/1ps
module tb_regfile_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file the sequencer drives; poke_* preloads it from the bench.
  logic [15:0] rf [8];
  logic        poke_en  = 1'b0;
  logic [2:0]  poke_idx = 3'd0;
  logic [15:0] poke_val = 16'd0;

  assign bus.rf_data_out = rf[bus.rf_readnum];

  always @(posedge clk) begin
    if (poke_en)           rf[poke_idx] <= poke_val;
    else if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_data_in;
  end

  typedef struct {
    int          lat;
    bit          err;
    bit          wr;
    logic [2:0]  rd;
    logic [15:0] val;
    bit          z;
    bit          n;
    bit          v;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_rf [8];
  bit          m_z, m_n, m_v;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  int         cyc = 0;
  int         acc_cyc = 0;
  int         wcnt = 0;
  logic [2:0] wnum = 3'd0;

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!reset) begin
      if (bus.rf_write) begin
        wcnt++;
        wnum = bus.rf_writenum;
      end
      if (bus.err && !bus.done) chk("err_without_done", 1, 0);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("err", bus.err, e.err);
          chk("write_count", wcnt, e.wr);
          if (e.wr) begin
            chk("writenum", wnum, e.rd);
            chk("reg_value", rf[e.rd], e.val);
          end
          chk("flag_z", bus.flag_z, e.z);
          chk("flag_n", bus.flag_n, e.n);
          chk("flag_v", bus.flag_v, e.v);
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc = cyc;
        wcnt    = 0;
      end
    end
  end

  task automatic poke(input logic [2:0] idx, input logic [15:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk); #1;
    poke_en  = 1'b0;
    m_rf[idx] = val;
  endtask

  // Reference model works from the opcode rules using integer arithmetic.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [7:0] imm, input bit keep, input bit track);
    exp_t e;
    int   a, b, sa, sb, d, dw, n;
    bit   rdy;
    a  = int'(m_rf[rn]);
    b  = int'(m_rf[rm]);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    e.rd  = rd;
    e.err = (op >= 3'd6);
    e.wr  = !(op == 3'd3 || op >= 3'd6);
    e.lat = (op == 3'd0) ? 2 : (op == 3'd2 || op == 3'd4) ? 5 : (op >= 3'd6) ? 1 : 4;
    e.val = 16'd0;
    case (op)
      3'd0: e.val = 16'((imm >= 8'd128) ? int'(imm) + 65536 - 256 : int'(imm));
      3'd1: e.val = 16'(b);
      3'd2: e.val = 16'((a + b) % 65536);
      3'd4: e.val = m_rf[rn] & m_rf[rm];
      3'd5: e.val = 16'(65535 - b);
      default: ;
    endcase
    if (track) begin
      if (op == 3'd3) begin
        d   = sa - sb;
        dw  = (d + 65536) % 65536;
        m_z = (dw == 0);
        m_n = (dw >= 32768);
        m_v = (d > 32767) || (d < -32768);
      end
      if (e.wr) m_rf[rd] = e.val;
      e.z = m_z;
      e.n = m_n;
      e.v = m_v;
      sbq.push_back(e);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rn    = rn;
    bus.cmd_rm    = rm;
    bus.cmd_imm   = imm;
    n = 0;
    while (1) begin
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.cmd_ready && sbq.size() == 0)) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rd    = 3'd0;
    bus.cmd_rn    = 3'd0;
    bus.cmd_rm    = 3'd0;
    bus.cmd_imm   = 8'd0;
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    @(posedge clk); #1;

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rf_write", bus.rf_write, 0);
    chk("rst_readnum", bus.rf_readnum, 0);
    chk("rst_writenum", bus.rf_writenum, 0);
    chk("rst_data_in", bus.rf_data_in, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_v}, 0);

    for (int i = 0; i < 8; i++) poke(3'(i), 16'($urandom));
    reset = 1'b0;

    issue(3'd0, 3'd3, 3'd0, 3'd0, 8'hF6, 0, 1);
    wait_idle();
    chk("mov_imm_r3", rf[3], 16'hFFF6);
    chk("mov_imm_flags", {bus.flag_z, bus.flag_n, bus.flag_v}, 0);

    issue(3'd0, 3'd1, 3'd0, 3'd0, 8'd7, 0, 1);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 8'd5, 0, 1);
    issue(3'd2, 3'd4, 3'd1, 3'd2, 8'd0, 0, 1);
    wait_idle();
    chk("add_r4", rf[4], 16'd12);

    poke(3'd0, 16'h7FFF);
    poke(3'd1, 16'hFFFF);
    issue(3'd3, 3'd7, 3'd0, 3'd1, 8'd0, 0, 1);
    wait_idle();
    chk("cmp_flags_vnz", {bus.flag_v, bus.flag_n, bus.flag_z}, 3'b110);
    issue(3'd3, 3'd0, 3'd5, 3'd5, 8'd0, 0, 1);
    wait_idle();
    chk("cmp_same_z", bus.flag_z, 1);

    issue(3'd6, 3'd1, 3'd0, 3'd0, 8'd0, 1, 1);
    chk("illegal_done", bus.done, 1);
    chk("illegal_err", bus.err, 1);
    chk("held_valid_not_ready", bus.cmd_ready, 0);
    issue(3'd6, 3'd1, 3'd0, 3'd0, 8'd0, 0, 1);
    wait_idle();

    poke(3'd6, 16'h1234);
    poke(3'd1, 16'hABCD);
    issue(3'd1, 3'd6, 3'd0, 3'd1, 8'd0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("write_before_reset", bus.rf_write, 1);
    reset = 1'b1;
    #1;
    chk("reset_drops_write", bus.rf_write, 0);
    chk("reset_ready", bus.cmd_ready, 1);
    chk("reset_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    chk("r6_kept", rf[6], 16'h1234);
    chk("reset_clears_z", bus.flag_z, 0);

    poke(3'd0, 16'h00FF);
    issue(3'd5, 3'd0, 3'd0, 3'd0, 8'd0, 0, 1);
    poke(3'd2, 16'hF0F0);
    poke(3'd3, 16'h3C3C);
    wait_idle();
    chk("mvn_r0", rf[0], 16'hFF00);
    issue(3'd4, 3'd7, 3'd2, 3'd3, 8'd0, 0, 1);
    wait_idle();
    chk("and_r7", rf[7], 16'h3030);
    poke(3'd2, 16'h0123);
    issue(3'd2, 3'd2, 3'd2, 3'd2, 8'd0, 0, 1);
    wait_idle();
    chk("add_double", rf[2], 16'h0246);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 0, 1);
    end
    wait_idle();
    for (int i = 0; i < 8; i++) chk("final_reg", rf[i], m_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
